// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the keypad number-entry engine:
//   - key-code constants as delivered by the keypad scanner (0..20)
//   - entry_state_t: EDIT / CONV / WRITE controller states
//   - digit_t and key_to_digit(): maps a key code onto a decimal digit
package keypad_pkg;

    // Control keys
    localparam logic [4:0] KEY_DOT   = 5'd1;
    localparam logic [4:0] KEY_ESC   = 5'd2;
    localparam logic [4:0] KEY_ENT   = 5'd4;
    localparam logic [4:0] KEY_F1    = 5'd5;   // toggle real/imag
    localparam logic [4:0] KEY_F2    = 5'd10;  // previous sample
    localparam logic [4:0] KEY_MINUS = 5'd11;
    localparam logic [4:0] KEY_F3    = 5'd15;  // next sample
    localparam logic [4:0] KEY_F4    = 5'd20;  // delete

    // Digit keys
    localparam logic [4:0] KEY_D0 = 5'd3;
    localparam logic [4:0] KEY_D1 = 5'd7;
    localparam logic [4:0] KEY_D2 = 5'd8;
    localparam logic [4:0] KEY_D3 = 5'd9;
    localparam logic [4:0] KEY_D4 = 5'd12;
    localparam logic [4:0] KEY_D5 = 5'd13;
    localparam logic [4:0] KEY_D6 = 5'd14;
    localparam logic [4:0] KEY_D7 = 5'd17;
    localparam logic [4:0] KEY_D8 = 5'd18;
    localparam logic [4:0] KEY_D9 = 5'd19;

    typedef enum logic [1:0] {
        EDIT  = 2'd0,
        CONV  = 2'd1,
        WRITE = 2'd2
    } entry_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] value;
    } digit_t;

    function automatic digit_t key_to_digit(input logic [4:0] key);
        digit_t d;
        d.valid = 1'b1;
        d.value = 4'd0;
        case (key)
            KEY_D0:  d.value = 4'd0;
            KEY_D1:  d.value = 4'd1;
            KEY_D2:  d.value = 4'd2;
            KEY_D3:  d.value = 4'd3;
            KEY_D4:  d.value = 4'd4;
            KEY_D5:  d.value = 4'd5;
            KEY_D6:  d.value = 4'd6;
            KEY_D7:  d.value = 4'd7;
            KEY_D8:  d.value = 4'd8;
            KEY_D9:  d.value = 4'd9;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/bcd_to_scaled_int.sv
// bcd_to_scaled_int
// Sequential BCD-to-binary converter: acc = acc*10 + digit, one digit per
// clock, most significant digit first. A start pulse clears the accumulator;
// N_DIGITS cycles later done pulses for one cycle and result holds the
// unsigned magnitude until the next start.
// Ports:
//   clk, srst   clock, synchronous active-high reset
//   start       one-cycle request; digits must stay stable until done
//   digits      N_DIGITS BCD nibbles, MSD in the top nibble
//   done        one-cycle pulse, result valid from this cycle on
//   result      unsigned binary magnitude
module bcd_to_scaled_int #(
    parameter int N_DIGITS = 7,
    parameter int DATA_W   = 24
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  start,
    input  logic [4*N_DIGITS-1:0] digits,
    output logic                  done,
    output logic [DATA_W-1:0]     result
);

    localparam int STEP_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_DIGITS - 1);

    logic              busy_reg;
    logic              done_reg;
    logic [STEP_W-1:0] step_reg;
    logic [DATA_W-1:0] acc_reg;
    logic [3:0]        digit_arr [N_DIGITS];
    logic [3:0]        digit_sel;

    // Re-order the packed nibbles so digit_arr[0] is the most significant one
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_unpack
        assign digit_arr[gi] = digits[4*(N_DIGITS-1-gi) +: 4];
    end

    assign digit_sel = digit_arr[step_reg];

    always_ff @(posedge clk) begin
        if (srst) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            step_reg <= '0;
            acc_reg  <= '0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                busy_reg <= 1'b1;
                step_reg <= '0;
                acc_reg  <= '0;
            end else if (busy_reg) begin
                acc_reg <= acc_reg * DATA_W'(10) + DATA_W'(digit_sel);
                if (step_reg == LAST_STEP) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end else begin
                    step_reg <= step_reg + STEP_W'(1);
                end
            end
        end
    end

    assign done   = done_reg;
    assign result = acc_reg;

endmodule

// File: rtl/keypad_value_entry.sv
// keypad_value_entry
// Keypad number-entry engine. Strobed key codes edit a signed decimal field
// (sign, up to INT_DIGITS integer digits, up to FRAC_DIGITS fraction digits).
// ENT converts the field to value*10^FRAC_DIGITS in two's complement and
// issues a one-cycle write for the current sample (o_idx, o_is_imag).
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_key_valid, i_key_value     key strobe and code 0..20
//   o_busy                       converting/writing, keys dropped
//   o_idx, o_is_imag             sample/field being edited
//   o_sign, o_dot                field flags
//   o_int_cnt, o_frac_cnt        digits held
//   o_int_bcd, o_frac_bcd        digits (int right aligned, frac left aligned)
//   o_wr_en/_idx/_is_imag/_data  commit strobe and payload
//   o_all_done                   commit of imag field of the last entry
//   o_key_err                    rejected key pulse
// Build option: define KEYPAD_ENTRY_AUTO_ADVANCE_EN to step real->imag->next
// sample after each commit; otherwise the selection holds.
module keypad_value_entry
    import keypad_pkg::*;
#(
    parameter int N_ENTRIES   = 8,
    parameter int INT_DIGITS  = 4,
    parameter int FRAC_DIGITS = 3,
    parameter int DATA_W      = 24,
    localparam int IDX_W      = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1,
    localparam int ICNT_W     = $clog2(INT_DIGITS + 1),
    localparam int FCNT_W     = $clog2(FRAC_DIGITS + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_key_valid,
    input  logic [4:0]               i_key_value,
    output logic                     o_busy,
    output logic [IDX_W-1:0]         o_idx,
    output logic                     o_is_imag,
    output logic                     o_sign,
    output logic                     o_dot,
    output logic [ICNT_W-1:0]        o_int_cnt,
    output logic [FCNT_W-1:0]        o_frac_cnt,
    output logic [4*INT_DIGITS-1:0]  o_int_bcd,
    output logic [4*FRAC_DIGITS-1:0] o_frac_bcd,
    output logic                     o_wr_en,
    output logic [IDX_W-1:0]         o_wr_idx,
    output logic                     o_wr_is_imag,
    output logic [DATA_W-1:0]        o_wr_data,
    output logic                     o_all_done,
    output logic                     o_key_err
);

    localparam int INT_W    = 4 * INT_DIGITS;
    localparam int FRAC_W   = 4 * FRAC_DIGITS;
    localparam int N_DIGITS = INT_DIGITS + FRAC_DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

    entry_state_t      state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic              is_imag_reg, is_imag_next;
    logic              sign_reg, sign_next;
    logic              dot_reg, dot_next;
    logic [ICNT_W-1:0] int_cnt_reg, int_cnt_next;
    logic [FCNT_W-1:0] frac_cnt_reg, frac_cnt_next;
    logic [INT_W-1:0]  int_bcd_reg, int_bcd_next;
    logic [FRAC_W-1:0] frac_bcd_reg, frac_bcd_next;
    logic              key_err_reg, key_err_next;
    logic [DATA_W-1:0] wr_data_reg, wr_data_next;

    logic              clear_field;
    logic              conv_start;
    logic              conv_done;
    logic [DATA_W-1:0] conv_mag;
    digit_t            key_digit;

    // Field digits stay frozen while converting, so they feed the converter
    // directly: right-aligned integer part followed by zero-padded fraction.
    bcd_to_scaled_int #(
        .N_DIGITS (N_DIGITS),
        .DATA_W   (DATA_W)
    ) u_conv (
        .clk    (i_clk),
        .srst   (i_rst),
        .start  (conv_start),
        .digits ({int_bcd_reg, frac_bcd_reg}),
        .done   (conv_done),
        .result (conv_mag)
    );

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        is_imag_next  = is_imag_reg;
        sign_next     = sign_reg;
        dot_next      = dot_reg;
        int_cnt_next  = int_cnt_reg;
        frac_cnt_next = frac_cnt_reg;
        int_bcd_next  = int_bcd_reg;
        frac_bcd_next = frac_bcd_reg;
        wr_data_next  = wr_data_reg;
        key_err_next  = 1'b0;
        clear_field   = 1'b0;
        conv_start    = 1'b0;
        key_digit     = key_to_digit(i_key_value);

        case (state_reg)
            EDIT: begin
                if (i_key_valid) begin
                    if (key_digit.valid) begin
                        if (!dot_reg) begin
                            if (int_cnt_reg < ICNT_W'(INT_DIGITS)) begin
                                int_bcd_next = (int_bcd_reg << 4) | INT_W'(key_digit.value);
                                int_cnt_next = int_cnt_reg + ICNT_W'(1);
                            end else begin
                                key_err_next = 1'b1;
                            end
                        end else begin
                            if (frac_cnt_reg < FCNT_W'(FRAC_DIGITS)) begin
                                // Fraction digits fill from the top nibble down
                                frac_bcd_next = frac_bcd_reg |
                                    (FRAC_W'(key_digit.value) << (4 * (FRAC_DIGITS - 1 - int'(frac_cnt_reg))));
                                frac_cnt_next = frac_cnt_reg + FCNT_W'(1);
                            end else begin
                                key_err_next = 1'b1;
                            end
                        end
                    end else begin
                        case (i_key_value)
                            KEY_DOT: begin
                                if (dot_reg) key_err_next = 1'b1;
                                else         dot_next     = 1'b1;
                            end
                            KEY_MINUS: sign_next = ~sign_reg;
                            KEY_F4: begin
                                if (frac_cnt_reg != '0) begin
                                    frac_bcd_next = frac_bcd_reg &
                                        ~(FRAC_W'(4'hF) << (4 * (FRAC_DIGITS - int'(frac_cnt_reg))));
                                    frac_cnt_next = frac_cnt_reg - FCNT_W'(1);
                                end else if (dot_reg) begin
                                    dot_next = 1'b0;
                                end else if (int_cnt_reg != '0) begin
                                    int_bcd_next = int_bcd_reg >> 4;
                                    int_cnt_next = int_cnt_reg - ICNT_W'(1);
                                end else begin
                                    sign_next = 1'b0;
                                end
                            end
                            KEY_ESC: clear_field = 1'b1;
                            KEY_F3: begin
                                clear_field = 1'b1;
                                idx_next    = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
                            end
                            KEY_F2: begin
                                clear_field = 1'b1;
                                idx_next    = (idx_reg == '0) ? LAST_IDX : idx_reg - IDX_W'(1);
                            end
                            KEY_F1: begin
                                clear_field  = 1'b1;
                                is_imag_next = ~is_imag_reg;
                            end
                            KEY_ENT: begin
                                conv_start = 1'b1;
                                state_next = CONV;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CONV: begin
                if (conv_done) begin
                    // -0 and empty fields both give zero magnitude, so no special case
                    wr_data_next = sign_reg ? (DATA_W'(0) - conv_mag) : conv_mag;
                    state_next   = WRITE;
                end
            end
            WRITE: begin
                clear_field = 1'b1;
                state_next  = EDIT;
`ifdef KEYPAD_ENTRY_AUTO_ADVANCE_EN
                if (is_imag_reg) begin
                    is_imag_next = 1'b0;
                    idx_next     = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
                end else begin
                    is_imag_next = 1'b1;
                end
`endif
            end
            default: state_next = EDIT;
        endcase

        if (clear_field) begin
            sign_next     = 1'b0;
            dot_next      = 1'b0;
            int_cnt_next  = '0;
            frac_cnt_next = '0;
            int_bcd_next  = '0;
            frac_bcd_next = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= EDIT;
            idx_reg      <= '0;
            is_imag_reg  <= 1'b0;
            sign_reg     <= 1'b0;
            dot_reg      <= 1'b0;
            int_cnt_reg  <= '0;
            frac_cnt_reg <= '0;
            int_bcd_reg  <= '0;
            frac_bcd_reg <= '0;
            key_err_reg  <= 1'b0;
            wr_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            is_imag_reg  <= is_imag_next;
            sign_reg     <= sign_next;
            dot_reg      <= dot_next;
            int_cnt_reg  <= int_cnt_next;
            frac_cnt_reg <= frac_cnt_next;
            int_bcd_reg  <= int_bcd_next;
            frac_bcd_reg <= frac_bcd_next;
            key_err_reg  <= key_err_next;
            wr_data_reg  <= wr_data_next;
        end
    end

    assign o_busy       = (state_reg != EDIT);
    assign o_idx        = idx_reg;
    assign o_is_imag    = is_imag_reg;
    assign o_sign       = sign_reg;
    assign o_dot        = dot_reg;
    assign o_int_cnt    = int_cnt_reg;
    assign o_frac_cnt   = frac_cnt_reg;
    assign o_int_bcd    = int_bcd_reg;
    assign o_frac_bcd   = frac_bcd_reg;
    assign o_wr_en      = (state_reg == WRITE);
    assign o_wr_idx     = idx_reg;
    assign o_wr_is_imag = is_imag_reg;
    assign o_wr_data    = wr_data_reg;
    assign o_all_done   = o_wr_en && is_imag_reg && (idx_reg == LAST_IDX);
    assign o_key_err    = key_err_reg;

endmodule

// File: tb/tb_keypad_value_entry.sv
module tb_keypad_value_entry;

    localparam int N  = 8;
    localparam int ID = 4;
    localparam int FD = 3;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_valid;
    logic [4:0]    key_value;
    logic          busy, is_imag, sign, dot, wr_en, wr_is_imag, all_done, key_err;
    logic [2:0]    idx, wr_idx;
    logic [2:0]    int_cnt;
    logic [1:0]    frac_cnt;
    logic [15:0]   int_bcd;
    logic [11:0]   frac_bcd;
    logic [DW-1:0] wr_data;

    keypad_value_entry #(
        .N_ENTRIES(N), .INT_DIGITS(ID), .FRAC_DIGITS(FD), .DATA_W(DW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_key_valid(key_valid), .i_key_value(key_value),
        .o_busy(busy), .o_idx(idx), .o_is_imag(is_imag), .o_sign(sign), .o_dot(dot),
        .o_int_cnt(int_cnt), .o_frac_cnt(frac_cnt), .o_int_bcd(int_bcd),
        .o_frac_bcd(frac_bcd), .o_wr_en(wr_en), .o_wr_idx(wr_idx),
        .o_wr_is_imag(wr_is_imag), .o_wr_data(wr_data), .o_all_done(all_done),
        .o_key_err(key_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_seen = 0;
    int done_exp  = 0;

    // Reference model: the field as digit lists plus flags
    int m_idx;
    bit m_imag, m_sign, m_dot;
    int m_int[$];
    int m_frac[$];
    int digit_of[32];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_clear();
        m_sign = 0; m_dot = 0;
        m_int.delete(); m_frac.delete();
    endtask

    task automatic model_reset();
        model_clear();
        m_idx = 0; m_imag = 0;
    endtask

    task automatic model_key(input int k, output bit err);
        err = 0;
        if (digit_of[k] >= 0) begin
            if (!m_dot) begin
                if (m_int.size() < ID) m_int.push_back(digit_of[k]); else err = 1;
            end else begin
                if (m_frac.size() < FD) m_frac.push_back(digit_of[k]); else err = 1;
            end
        end else begin
            case (k)
                1:  if (m_dot) err = 1; else m_dot = 1;
                2:  model_clear();
                5:  begin model_clear(); m_imag = !m_imag; end
                10: begin model_clear(); m_idx = (m_idx + N - 1) % N; end
                11: m_sign = !m_sign;
                15: begin model_clear(); m_idx = (m_idx + 1) % N; end
                20: begin
                    if (m_frac.size() > 0)    void'(m_frac.pop_back());
                    else if (m_dot)           m_dot = 0;
                    else if (m_int.size() > 0) void'(m_int.pop_back());
                    else                      m_sign = 0;
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [15:0] exp_int_bcd();
        logic [15:0] v = 0;
        foreach (m_int[i]) v = (v << 4) | 16'(m_int[i]);
        return v;
    endfunction

    function automatic logic [11:0] exp_frac_bcd();
        logic [11:0] v = 0;
        for (int i = 0; i < FD; i++) v = (v << 4) | 12'((i < m_frac.size()) ? m_frac[i] : 0);
        return v;
    endfunction

    function automatic longint exp_value();
        longint mag = 0;
        foreach (m_int[i]) mag = mag * 10 + m_int[i];
        for (int i = 0; i < FD; i++) mag = mag * 10 + ((i < m_frac.size()) ? m_frac[i] : 0);
        return m_sign ? -mag : mag;
    endfunction

    task automatic check_field();
        check("sign", sign, m_sign);
        check("dot", dot, m_dot);
        check("int_cnt", int_cnt, m_int.size());
        check("frac_cnt", frac_cnt, m_frac.size());
        check("int_bcd", int_bcd, exp_int_bcd());
        check("frac_bcd", frac_bcd, exp_frac_bcd());
        check("idx", idx, m_idx);
        check("is_imag", is_imag, m_imag);
        check("busy_idle", busy, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_idx"}, idx, 0);
        check({tag, "_imag"}, is_imag, 0);
        check({tag, "_sign"}, sign, 0);
        check({tag, "_dot"}, dot, 0);
        check({tag, "_icnt"}, int_cnt, 0);
        check({tag, "_fcnt"}, frac_cnt, 0);
        check({tag, "_ibcd"}, int_bcd, 0);
        check({tag, "_fbcd"}, frac_bcd, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_idx"}, wr_idx, 0);
        check({tag, "_wr_imag"}, wr_is_imag, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_all_done"}, all_done, 0);
        check({tag, "_key_err"}, key_err, 0);
    endtask

    task automatic press(input int k);
        bit e;
        @(negedge clk); key_valid = 1; key_value = 5'(k);
        @(negedge clk); key_valid = 0;
        model_key(k, e);
        check("key_err", key_err, e);
        check_field();
        $display("key %0d err=%0b int_cnt=%0d frac_cnt=%0d", k, key_err, int_cnt, frac_cnt);
    endtask

    // ENT, then wait (bounded) for the commit; optionally strobe minus mid-CONV
    task automatic do_ent(input bit inject);
        int lat;
        bit found;
        longint lv;
        logic [DW-1:0] e;
        bit exp_done;
        lat = 0; found = 0;
        @(negedge clk); key_valid = 1; key_value = 5'd4;
        @(negedge clk); key_valid = 0;
        check("busy_conv", busy, 1);
        for (int c = 1; c <= 20 && !found; c++) begin
            if (inject && c == 3) begin key_valid = 1; key_value = 5'd11; end
            @(negedge clk); key_valid = 0;
            if (inject && c == 3) begin
                check("busy_drop_err", key_err, 0);
                check("busy_drop_sign", sign, m_sign);
            end
            if (wr_en) begin found = 1; lat = c; end
        end
        check("wr_seen", found, 1);
        lv = exp_value();
        e = lv[DW-1:0];
        exp_done = m_imag && (m_idx == N - 1);
        check("ent_latency", lat, ID + FD + 1);
        check("wr_data", wr_data, e);
        check("wr_idx", wr_idx, m_idx);
        check("wr_is_imag", wr_is_imag, m_imag);
        check("all_done", all_done, exp_done);
        check("busy_write", busy, 1);
        if (all_done) done_seen++;
        if (exp_done) done_exp++;
        $display("write idx=%0d imag=%0b data=%0d all_done=%0b lat=%0d",
                 wr_idx, wr_is_imag, $signed(wr_data), all_done, lat);
        model_clear();
`ifdef KEYPAD_ENTRY_AUTO_ADVANCE_EN
        if (m_imag) begin m_imag = 0; m_idx = (m_idx + 1) % N; end
        else m_imag = 1;
`endif
        @(negedge clk);
        check("wr_en_pulse", wr_en, 0);
        check("all_done_pulse", all_done, 0);
        check_field();
    endtask

    task automatic reset_dut();
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        model_reset();
        check_zero("srst");
        $display("reset");
    endtask

    task automatic reset_during_conv();
        bit seen = 0;
        @(negedge clk); key_valid = 1; key_value = 5'd4;
        @(negedge clk); key_valid = 0;
        @(negedge clk);
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        model_reset();
        check_zero("conv_rst");
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (wr_en) seen = 1;
        end
        check("no_wr_after_rst", seen, 0);
        $display("reset during CONV, wr_en seen=%0b", seen);
    endtask

    int edit_keys[17] = '{3, 7, 8, 9, 12, 13, 14, 17, 18, 19, 1, 11, 20, 2, 5, 10, 15};

    initial begin
        for (int i = 0; i < 32; i++) digit_of[i] = -1;
        digit_of[3] = 0;  digit_of[7] = 1;  digit_of[8] = 2;  digit_of[9] = 3;
        digit_of[12] = 4; digit_of[13] = 5; digit_of[14] = 6;
        digit_of[17] = 7; digit_of[18] = 8; digit_of[19] = 9;

        rst = 1; key_valid = 0; key_value = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        model_reset();
        check_zero("init");

        // "-12.5"
        press(11); press(7); press(8); press(1); press(13);
        do_ent(0);

        // five integer digits, fifth rejected; minus strobed during CONV
        reset_dut();
        press(7); press(8); press(9); press(12); press(13);
        do_ent(1);

        // "3.1416", fourth fraction digit rejected
        reset_dut();
        press(9); press(1); press(7); press(12); press(7); press(14);
        do_ent(0);

        // delete chain on "-0.5", plus extra deletes on an empty field
        press(11); press(3); press(1); press(13);
        repeat (5) press(20);
        press(1); press(1);

        // sixteen empty commits
        reset_dut();
        done_seen = 0; done_exp = 0;
        repeat (16) do_ent(0);
        check("all_done_count", done_seen, done_exp);

        // reset while converting
        press(8); press(11);
        reset_during_conv();

        // randomized editing with occasional commits
        for (int i = 0; i < 400; i++) begin
            int k;
            if ($urandom_range(0, 1) == 0) k = edit_keys[$urandom_range(0, 16)];
            else                           k = int'($urandom_range(0, 31));
            if (k == 4) do_ent($urandom_range(0, 1) == 1);
            else        press(k);
        end
        do_ent(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
